// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between port A and port B.
// Each access is a fixed three cycles: IDLE (grant) -> ACCESS (memory strobe) -> DONE (ack).
module dmem_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic              last_b;
    logic              gnt_b;
    logic              lat_we;
    logic              lat_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] a_rd_q;
    logic [DATA_W-1:0] b_rd_q;

    logic              sel_b_c;
    logic              sel_we_c;
    logic              sel_ok_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic [DATA_W-1:0] rd_data_c;

    // Winner selection: a tie goes to the port that was not granted last.
    always_comb begin
        sel_b_c     = b_req && (!a_req || !last_b);
        sel_we_c    = sel_b_c ? b_we    : a_we;
        sel_addr_c  = sel_b_c ? b_addr  : a_addr;
        sel_wdata_c = sel_b_c ? b_wdata : a_wdata;
        sel_ok_c    = (sel_addr_c < DEPTH_A);
        rd_data_c   = rd_ok ? mem_rdata : '0;
    end

    // Memory read data only exists during DONE, so it is forwarded with the ack
    // and captured into the hold register as DONE ends.
    assign a_rdata = a_ack ? rd_data_c : a_rd_q;
    assign b_rdata = b_ack ? rd_data_c : b_rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            gnt_b     <= 1'b0;
            lat_we    <= 1'b0;
            lat_ok    <= 1'b0;
            rd_ok     <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_err     <= 1'b0;
            b_err     <= 1'b0;
            a_rd_q    <= '0;
            b_rd_q    <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            unique case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        gnt_b  <= sel_b_c;
                        last_b <= sel_b_c;
                        lat_we <= sel_we_c;
                        lat_ok <= sel_ok_c;
                        // Out-of-range accesses never strobe the memory.
                        if (sel_ok_c) begin
                            mem_we    <= sel_we_c;
                            mem_re    <= !sel_we_c;
                            mem_addr  <= sel_addr_c;
                            mem_wdata <= sel_wdata_c;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    rd_ok <= lat_ok && !lat_we;
                    if (gnt_b) begin
                        b_ack <= 1'b1;
                        b_err <= !lat_ok;
                    end else begin
                        a_ack <= 1'b1;
                        a_err <= !lat_ok;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (gnt_b) begin
                        b_rd_q <= rd_data_c;
                    end else begin
                        a_rd_q <= rd_data_c;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural registered-read memory and
// an in-order scoreboard of expected acks.
module tb_dmem_arbiter;

    typedef struct {
        logic        pb;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_clr;
    logic        a_req, a_we, a_ack, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_ack, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_arr [0:31];

    exp_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(32)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem_arr[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_we) mem_arr[mem_addr[4:0]] <= mem_wdata;
            if (mem_re) mem_rdata <= mem_arr[mem_addr[4:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string tag, input logic pb, input int budget, output int cyc);
        cyc = 0;
        while (!(pb ? b_ack : a_ack) && cyc < budget) begin
            tick();
            cyc++;
        end
        chk(tag, 32'(pb ? b_ack : a_ack), 32'd1);
    endtask

    task automatic push(input logic pb, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.pb = pb;
        e.rdata = rdata;
        e.err = err;
        sbq.push_back(e);
    endtask

    // Scoreboard and memory-strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mem_we || mem_re) chk("mem_we_re_excl", 32'(mem_we & mem_re), 32'd0);
        if (a_ack || b_ack) begin
            chk("ack_onehot", 32'(a_ack & b_ack), 32'd0);
            chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_port", 32'(b_ack), 32'(e.pb));
                chk("sb_rdata", b_ack ? b_rdata : a_rdata, e.rdata);
                chk("sb_err", 32'(b_ack ? b_err : a_err), 32'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1; mem_clr = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; mem_clr = 1'b0;
        chk("rst_a_ack", 32'(a_ack), 32'd0);
        chk("rst_b_ack", 32'(b_ack), 32'd0);
        chk("rst_mem_we_re", 32'({mem_we, mem_re}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_b_err", 32'(b_err), 32'd0);

        // A writes 0xDEADBEEF to word 5.
        push(1'b0, 32'd0, 1'b0);
        a_we = 1'b1; a_addr = 32'd5; a_wdata = 32'hDEADBEEF; a_req = 1'b1;
        tick();
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_re", 32'(mem_re), 32'd0);
        chk("wr_mem_addr", mem_addr, 32'd5);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_early_ack", 32'(a_ack), 32'd0);
        tick();
        chk("wr_a_ack", 32'(a_ack), 32'd1);
        chk("wr_a_err", 32'(a_err), 32'd0);
        chk("wr_done_mem_we", 32'(mem_we), 32'd0);
        tick();
        a_req = 1'b0;
        tick();

        // A reads word 5 back.
        push(1'b0, 32'hDEADBEEF, 1'b0);
        a_we = 1'b0; a_req = 1'b1;
        tick();
        chk("rd_mem_re", 32'(mem_re), 32'd1);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("rd_mem_addr", mem_addr, 32'd5);
        tick();
        chk("rd_a_ack", 32'(a_ack), 32'd1);
        chk("rd_a_rdata", a_rdata, 32'hDEADBEEF);
        tick();
        a_req = 1'b0;
        chk("rd_ack_pulse", 32'(a_ack), 32'd0);
        chk("rd_rdata_hold", a_rdata, 32'hDEADBEEF);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_a_rdata", a_rdata, 32'd0);

        // Tie after reset: A (read @1) first, B (write @2) three cycles later.
        push(1'b0, 32'd0, 1'b0);
        push(1'b1, 32'd0, 1'b0);
        a_we = 1'b0; a_addr = 32'd1; a_req = 1'b1;
        b_we = 1'b1; b_addr = 32'd2; b_wdata = 32'h12345678; b_req = 1'b1;
        wait_ack("tie1_a_ack", 1'b0, 10, c);
        chk("tie1_a_lat", 32'(c), 32'd2);
        chk("tie1_b_wait", 32'(b_ack), 32'd0);
        tick();
        a_req = 1'b0;
        wait_ack("tie1_b_ack", 1'b1, 10, c);
        chk("tie1_b_gap", 32'(c), 32'd2);
        tick();
        b_req = 1'b0;
        tick();

        // A-only write leaves A as last grant, so the next tie goes to B.
        push(1'b0, 32'd0, 1'b0);
        a_we = 1'b1; a_addr = 32'd1; a_wdata = 32'hCAFE0001; a_req = 1'b1;
        wait_ack("solo_a_ack", 1'b0, 10, c);
        tick();
        a_req = 1'b0;
        tick();

        push(1'b1, 32'hCAFE0001, 1'b0);
        push(1'b0, 32'h12345678, 1'b0);
        a_we = 1'b0; a_addr = 32'd2; a_req = 1'b1;
        b_we = 1'b0; b_addr = 32'd1; b_req = 1'b1;
        wait_ack("tie2_b_ack", 1'b1, 10, c);
        chk("tie2_b_lat", 32'(c), 32'd2);
        chk("tie2_a_wait", 32'(a_ack), 32'd0);
        tick();
        b_req = 1'b0;
        wait_ack("tie2_a_ack", 1'b0, 10, c);
        chk("tie2_a_gap", 32'(c), 32'd2);
        tick();
        a_req = 1'b0;
        tick();

        // B reads word 32: out of range, no memory strobe.
        push(1'b1, 32'd0, 1'b1);
        b_we = 1'b0; b_addr = 32'd32; b_req = 1'b1;
        tick();
        chk("oor_mem_we", 32'(mem_we), 32'd0);
        chk("oor_mem_re", 32'(mem_re), 32'd0);
        tick();
        chk("oor_b_ack", 32'(b_ack), 32'd1);
        chk("oor_b_err", 32'(b_err), 32'd1);
        chk("oor_b_rdata", b_rdata, 32'd0);
        chk("oor_done_mem_re", 32'(mem_re), 32'd0);
        tick();
        b_req = 1'b0;
        chk("oor_err_hold", 32'(b_err), 32'd1);
        tick();

        // Reset during ACCESS aborts the access; held request restarts afterwards.
        a_we = 1'b1; a_addr = 32'd3; a_wdata = 32'h55; a_req = 1'b1;
        tick();
        chk("abort_mem_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_mem_we_off", 32'(mem_we), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_no_ack", 32'(a_ack), 32'd0);
        push(1'b0, 32'd0, 1'b0);
        tick();
        chk("restart_mem_we", 32'(mem_we), 32'd1);
        chk("restart_mem_addr", mem_addr, 32'd3);
        chk("restart_no_ack", 32'(a_ack), 32'd0);
        tick();
        chk("restart_a_ack", 32'(a_ack), 32'd1);
        tick();
        a_req = 1'b0;
        tick();

        // Both ports saturated: grants alternate A,B,A,B...
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) push(1'b0, 32'd0, 1'b0);
            else push(1'b1, 32'hA0A0A0A0, 1'b0);
        end
        a_we = 1'b1; a_addr = 32'd10; a_wdata = 32'hA0A0A0A0; a_req = 1'b1;
        b_we = 1'b0; b_addr = 32'd10; b_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c = 0;
            do begin
                tick();
                c++;
            end while (!(a_ack || b_ack) && c < 10);
            chk("sat_grant", 32'(b_ack), 32'(i % 2));
            chk("sat_gap", 32'(c), (i == 0) ? 32'd2 : 32'd3);
        end
        tick();
        a_req = 1'b0; b_req = 1'b0;
        repeat (4) tick();
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
